// File: rtl/rnn_host.sv
// Host sequencer for the RNN accelerator: forwards parameter/step/run commands as bus writes and polls for the run result.
// Latency: bus write one cycle after command acceptance; RNN_HOST_PERF_EN builds the run cycle counter.
// Backpressure: cmd_ready stays low until the command completes and any result has been taken via res_ready.
module rnn_host #(
    parameter int STEP_CYCLES = 16,
    parameter int POLL_MAX    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wrdata,
    input  logic [31:0] m_rddata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic [31:0] perf_cycles
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WRITE, STEP_WAIT, POLL, READ_RES, RESULT} state_t;

    state_t        state;
    logic [2:0]    addr_q;
    logic [SW-1:0] step_cnt;
    logic [PW-1:0] poll_cnt;
    logic          unused_rddata;

    assign unused_rddata = ^m_rddata[31:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            addr_q    <= '0;
            step_cnt  <= '0;
            poll_cnt  <= '0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_addr    <= '0;
            m_wrdata  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is registered, so it first rises one cycle after reset release
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state     <= WRITE;
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        m_write   <= 1'b1;
                        m_addr    <= {29'd0, cmd_addr};
                        m_wrdata  <= cmd_data;
                    end
                end
                WRITE: begin
                    m_write  <= 1'b0;
                    m_wrdata <= '0;
                    m_addr   <= '0;
                    case (addr_q)
                        3'd0: begin
                            state    <= STEP_WAIT;
                            step_cnt <= STEP_LAST;
                        end
                        3'd7: begin
                            state    <= POLL;
                            poll_cnt <= '0;
                            m_read   <= 1'b1;
                        end
                        default: begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end
                    endcase
                end
                STEP_WAIT: begin
                    if (step_cnt == '0) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt - 1'b1;
                    end
                end
                POLL: begin
                    // done is tested before the limit so a hit on the last poll is a success
                    if (m_rddata[0]) begin
                        state  <= READ_RES;
                        m_addr <= 32'd7;
                    end else if (poll_cnt == POLL_LAST) begin
                        state     <= RESULT;
                        m_read    <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                READ_RES: begin
                    state     <= RESULT;
                    m_read    <= 1'b0;
                    m_addr    <= '0;
                    res_valid <= 1'b1;
                    res_data  <= m_rddata[15:0];
                    res_err   <= 1'b0;
                end
                RESULT: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RNN_HOST_PERF_EN
    logic [31:0] perf_cnt;

    // Counts the run's WRITE cycle plus every POLL and READ_RES cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == WRITE && addr_q == 3'd7)
                perf_cnt <= 32'd1;
            else if (state == POLL || state == READ_RES)
                perf_cnt <= perf_cnt + 32'd1;
            if (state == READ_RES || (state == POLL && !m_rddata[0] && poll_cnt == POLL_LAST))
                perf_cycles <= perf_cnt + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_rnn_host.sv
// Bench for rnn_host: directed vectors, a run table and randomized runs against a result model.
module tb_rnn_host;

    localparam int PM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wrdata;
    logic [31:0] m_rddata;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;
    logic [31:0] perf_cycles;

    int tests = 0;
    int fails = 0;
    int writes = 0;
    int reads0 = 0;
    int reads7 = 0;
    int base0 = 0;
    int done_at = 1000;
    logic [31:0] res_word = '0;

    rnn_host #(.STEP_CYCLES(16), .POLL_MAX(PM)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wrdata(m_wrdata), .m_rddata(m_rddata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // Bus model: status reports done on poll number done_at of the current run
    assign m_rddata = (m_read && m_addr == 32'd7) ? res_word :
                      (m_read && m_addr == 32'd0 && (reads0 - base0) == done_at) ? 32'h1 : 32'h0;

    typedef struct {
        int          done;
        logic [31:0] word;
        int          r0;
        int          r7;
        logic        err;
        logic [15:0] res;
        int          perf;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("strobe_exclusive", {31'd0, m_read & m_write}, 32'd0);
        check("idle_bus_zero", {31'd0, !m_read && !m_write && (m_addr != 0 || m_wrdata != 0)}, 32'd0);
        if (m_write) writes++;
        if (m_read && m_addr == 32'd0) reads0++;
        if (m_read && m_addr == 32'd7) reads7++;
    endtask

    task automatic send(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic predict(input int done, input logic [31:0] word, output vec_t v);
        v.done = done;
        v.word = word;
        v.err  = (done > PM);
        v.r0   = v.err ? PM : done;
        v.r7   = v.err ? 0 : 1;
        v.res  = v.err ? 16'h0 : word[15:0];
        v.perf = v.r0 + 1 + v.r7;
    endtask

    task automatic run_and_check(input vec_t v);
        int b7;
        int n = 0;
        logic [31:0] d;
        base0    = reads0;
        b7       = reads7;
        done_at  = v.done;
        res_word = v.word;
        d = $urandom;
        send(3'd7, d);
        check("run_write_addr", m_addr, 32'd7);
        check("run_write_data", m_wrdata, d);
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        check("run_res_valid", {31'd0, res_valid}, 32'd1);
        check("run_polls", reads0 - base0, v.r0);
        check("run_res_reads", reads7 - b7, v.r7);
        check("run_res_err", {31'd0, res_err}, {31'd0, v.err});
        check("run_res_data", {16'd0, res_data}, {16'd0, v.res});
`ifdef RNN_HOST_PERF_EN
        check("run_perf", perf_cycles, v.perf);
`else
        check("run_perf", perf_cycles, 32'd0);
`endif
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("release_res_valid", {31'd0, res_valid}, 32'd0);
        check("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic write_and_check(input logic [2:0] a, input logic [31:0] d);
        send(a, d);
        check("wr_strobe", {31'd0, m_write}, 32'd1);
        check("wr_addr", m_addr, {29'd0, a});
        check("wr_data", m_wrdata, d);
        check("wr_busy", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("wr_one_cycle", {31'd0, m_write}, 32'd0);
        check("wr_ready_again", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, r0s, r7s;
        vec_t v;

        tbl[0] = '{done: 3,   word: 32'h0000FF38, r0: 3,  r7: 1, err: 1'b0, res: 16'hFF38, perf: 5};
        tbl[1] = '{done: 1,   word: 32'h5A5A1234, r0: 1,  r7: 1, err: 1'b0, res: 16'h1234, perf: 3};
        tbl[2] = '{done: PM,  word: 32'h00008001, r0: PM, r7: 1, err: 1'b0, res: 16'h8001, perf: PM + 2};
        tbl[3] = '{done: 999, word: 32'h0000BEEF, r0: PM, r7: 0, err: 1'b1, res: 16'h0000, perf: PM + 1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_strobes", {30'd0, m_read, m_write}, 32'd0);
        check("rst_perf", perf_cycles, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        write_and_check(3'd2, 32'h010300A5);
        for (int i = 0; i < 6; i++)
            write_and_check(3'($urandom_range(1, 6)), $urandom);

        // Step: one write then exactly 16 silent cycles
        send(3'd0, 32'hDEAD0001);
        check("step_write", {31'd0, m_write}, 32'd1);
        check("step_addr", m_addr, 32'd0);
        w0 = writes;
        r0s = reads0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("step_busy", {31'd0, cmd_ready}, 32'd0);
        end
        check("step_no_bus", writes - w0 + reads0 - r0s, 32'd0);
        tick();
        check("step_ready_at_18", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            run_and_check(tbl[i]);
            release_result();
        end

        for (int i = 0; i < 8; i++) begin
            predict($urandom_range(1, PM + 2), $urandom, v);
            run_and_check(v);
            release_result();
        end

        // Backpressure with a command waiting
        predict(2, 32'h00007777, v);
        run_and_check(v);
        cmd_valid = 1'b1;
        cmd_addr = 3'd3;
        cmd_data = 32'h12345678;
        w0 = writes;
        r0s = reads0;
        r7s = reads7;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res_data", {16'd0, res_data}, 32'h7777);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        check("bp_no_bus", writes - w0 + reads0 - r0s + reads7 - r7s, 32'd0);
        cmd_valid = 1'b0;
        release_result();

        // Reset in the middle of polling
        base0 = reads0;
        done_at = 1000;
        send(3'd7, 32'h0);
        tick();
        tick();
        check("poll_active", {31'd0, m_read}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_read", {31'd0, m_read}, 32'd0);
        check("rst_mid_addr", m_addr, 32'd0);
        check("rst_mid_outs", {28'd0, cmd_ready, res_valid, m_write, res_err}, 32'd0);
        check("rst_mid_data", {16'd0, res_data}, 32'd0);
        r0s = reads0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_mid_no_bus", reads0 - r0s, 32'd0);
        write_and_check(3'd2, 32'h010300A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rnn_host.md
RNN_HOST -- requirements
Module: rnn_host

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 16, meaning idle cycles waited after a step write (legal >= 1).
REQ-002 SHALL have parameter POLL_MAX, default 1024, meaning maximum status polls per run before timeout (legal >= 1).
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_addr  input  3  accelerator word address; 0 = step, 1-6 = parameter write, 7 = run.
REQ-008 SHALL have port cmd_data  input  32  write data, passed unmodified (bits 31:16 carry tensor select fields, bits 15:0 the fixed-point value).
REQ-009 SHALL have ports m_read / m_write  output  1 each  accelerator bus strobes.
REQ-010 SHALL have port m_addr  output  32  bus address; cmd_addr zero-extended.
REQ-011 SHALL have port m_wrdata  output  32  bus write data.
REQ-012 SHALL have port m_rddata  input  32  bus read data, valid in the same cycle as m_read (no waitrequest, zero wait states).
REQ-013 SHALL have ports res_valid  output  1, res_ready  input  1, res_data  output  16, res_err  output  1: run result handshake.
REQ-014 SHALL have port perf_cycles  output  32  poll-cycle count of the last run.

Function
REQ-015 SHALL implement states IDLE, WRITE, STEP_WAIT, POLL, READ_RES, RESULT.
REQ-016 cmd_ready SHALL equal (state == IDLE); one command is accepted per cycle in which cmd_valid and cmd_ready are both high.
REQ-017 On acceptance the block SHALL register cmd_addr and cmd_data and enter WRITE; in WRITE it SHALL drive m_write=1, m_addr=cmd_addr, m_wrdata=cmd_data for exactly one cycle.
REQ-018 From WRITE, cmd_addr 1-6 SHALL go to IDLE, cmd_addr 0 SHALL go to STEP_WAIT, and cmd_addr 7 SHALL go to POLL.
REQ-019 STEP_WAIT SHALL hold both strobes low for exactly STEP_CYCLES cycles, then enter IDLE.
REQ-020 POLL SHALL drive m_read=1 and m_addr=0 every cycle and count polls; if m_rddata[0]=1 it SHALL enter READ_RES.
REQ-021 If POLL_MAX polls complete without done, POLL SHALL enter RESULT with res_data=0 and res_err=1.
REQ-022 READ_RES SHALL drive m_read=1 and m_addr=7 for one cycle, capture m_rddata[15:0] into res_data, clear res_err, and enter RESULT.
REQ-023 RESULT SHALL hold res_valid=1 with res_data and res_err stable until res_ready=1; in that cycle it SHALL clear res_valid and enter IDLE.
REQ-024 m_read and m_write SHALL never be high in the same cycle; both SHALL be low in IDLE and RESULT, and m_addr/m_wrdata SHALL be 0 whenever no strobe is high.
REQ-025 The poll counter SHALL be $clog2(POLL_MAX+1) bits wide, cleared on each run entry; a done indication on the final allowed poll SHALL count as success, not timeout.

Reset
REQ-026 rst SHALL asynchronously force IDLE and drive all outputs to 0, including cmd_ready; cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-027 rst asserted mid-operation SHALL drop the strobes in the same cycle, discard the pending command and result, and issue no further bus transaction.

Configuration
REQ-028 Macro RNN_HOST_PERF_EN defined: perf_cycles SHALL count cycles from WRITE of a run through READ_RES inclusive, and SHALL update when RESULT is entered and hold until the next run's RESULT.
REQ-029 Macro RNN_HOST_PERF_EN undefined: no counter is built and perf_cycles SHALL be tied to 0.

Verification
REQ-030 Write: after reset, send cmd_addr=2, cmd_data=0x010300A5 -> the next cycle shows m_write=1, m_addr=2, m_wrdata=0x010300A5 for one cycle; cmd_ready is high again the following cycle.
REQ-031 Step: send cmd_addr=0 -> one m_write at addr 0, then 16 cycles with no strobes; cmd_ready is high 18 cycles after acceptance.
REQ-032 Run: the bus model returns status 1 on the 3rd poll and 0x0000FF38 at addr 7 -> exactly 3 reads at addr 0 and 1 read at addr 7; res_valid=1, res_data=0xFF38, res_err=0; with the macro defined, perf_cycles=5.
REQ-033 Timeout: POLL_MAX=4 and status is never 1 -> exactly 4 polls and no addr-7 read; res_valid=1, res_err=1, res_data=0.
REQ-034 Backpressure: hold res_ready low for 10 cycles while cmd_valid=1 -> res_valid and res_data stay stable, cmd_ready stays 0, and no bus activity occurs; raising res_ready returns the block to IDLE.
REQ-035 Reset mid-poll: assert rst during POLL -> m_read falls in the same cycle and all outputs are 0; after release, a new write command works as in REQ-030.
